// File: rtl/set_assoc_cache.sv
// N-way, M-set associative word cache with valid/ready handshake, per-set round-robin
// replacement and multi-cycle flush. Define SET_ASSOC_CACHE_STATS_EN for hit/miss counters.
module set_assoc_cache #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_data,
    input  logic              flush,
    output logic              flush_busy
`ifdef SET_ASSOC_CACHE_STATS_EN
    ,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {StIdle, StLookup, StResp, StFlush} state_e;

    state_e             state_q, state_d;
    logic               flush_pend_q, flush_pend_d;
    logic [IDX_W-1:0]   flush_idx_q, flush_idx_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    valid_d [SETS];
    logic [WAY_W-1:0]   rr_q [SETS];
    logic [WAY_W-1:0]   rr_d [SETS];
    logic [TAG_W-1:0]   tag_q [SETS][WAYS];
    logic [DATA_W-1:0]  data_q [SETS][WAYS];

    logic [IDX_W-1:0]   set_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit, has_inv, line_we, ready_int;
    logic [WAY_W-1:0]   hit_way, inv_way, line_way, rr_inc;

    assign set_idx = addr_q[IDX_W-1:0];
    assign req_tag = addr_q[ADDR_W-1:IDX_W];

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[set_idx][w]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign rr_inc   = (rr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[set_idx] + 1'b1;
    assign line_way = hit ? hit_way : (has_inv ? inv_way : rr_q[set_idx]);

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        flush_idx_d  = flush_idx_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_hit_d   = resp_hit_q;
        resp_data_d  = resp_data_q;
        valid_d      = valid_q;
        rr_d         = rr_q;
        line_we      = 1'b0;
        ready_int    = 1'b0;
        case (state_q)
            StIdle: begin
                if (flush || flush_pend_q) begin
                    state_d      = StFlush;
                    flush_pend_d = 1'b0;
                    flush_idx_d  = '0;
                end else begin
                    ready_int = 1'b1;
                    if (req_valid) begin
                        wr_d    = req_write;
                        addr_d  = req_addr;
                        wdata_d = req_data;
                        state_d = StLookup;
                    end
                end
            end
            StLookup: begin
                if (flush) flush_pend_d = 1'b1;
                resp_hit_d  = hit;
                resp_data_d = (!wr_q && hit) ? data_q[set_idx][hit_way] : '0;
                if (wr_q) begin
                    line_we                    = 1'b1;
                    valid_d[set_idx][line_way] = 1'b1;
                    if (!hit && !has_inv) rr_d[set_idx] = rr_inc;
                end
                state_d = StResp;
            end
            StResp: begin
                if (flush) flush_pend_d = 1'b1;
                if (resp_ready) begin
                    state_d     = StIdle;
                    resp_hit_d  = 1'b0;
                    resp_data_d = '0;
                end
            end
            StFlush: begin
                valid_d[flush_idx_q] = '0;
                for (int s = 0; s < SETS; s++) rr_d[s] = '0;
                if (flush_idx_q == IDX_W'(SETS - 1)) state_d = StIdle;
                else flush_idx_d = flush_idx_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            flush_pend_q <= 1'b0;
            flush_idx_q  <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            flush_idx_q  <= flush_idx_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_hit_q   <= resp_hit_d;
            resp_data_q  <= resp_data_d;
            valid_q      <= valid_d;
            rr_q         <= rr_d;
        end
    end

    // Line payload needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clock) begin
        if (line_we) begin
            tag_q[set_idx][line_way]  <= req_tag;
            data_q[set_idx][line_way] <= wdata_q;
        end
    end

    assign req_ready  = ready_int & reset_n;
    assign resp_valid = (state_q == StResp);
    assign resp_hit   = resp_hit_q;
    assign resp_data  = resp_data_q;
    assign flush_busy = flush_pend_q | (state_q == StFlush);

`ifdef SET_ASSOC_CACHE_STATS_EN
    logic [15:0] hits_q, hits_d, misses_q, misses_d;

    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        if (state_q == StFlush && flush_idx_q == '0) begin
            hits_d   = '0;
            misses_d = '0;
        end else if (state_q == StLookup) begin
            if (hit && hits_q != 16'hFFFF) hits_d = hits_q + 16'd1;
            if (!hit && misses_q != 16'hFFFF) misses_d = misses_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed table-driven bench for set_assoc_cache (WAYS=2, SETS=4), plus hand-written
// sequences for back-pressure, flush timing and reset in mid-transaction.
module tb_set_assoc_cache;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic        resp_hit;
    logic [31:0] resp_data;
    logic        flush = 1'b0;
    logic        flush_busy;
`ifdef SET_ASSOC_CACHE_STATS_EN
    logic [15:0] stat_hits, stat_misses;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    set_assoc_cache dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .resp_data  (resp_data),
        .flush      (flush),
        .flush_busy (flush_busy)
`ifdef SET_ASSOC_CACHE_STATS_EN
        ,
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    typedef struct packed {
        logic        rst;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        hit;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller sits 1 time unit after a posedge; returns there too.
    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: req_ready got 0 expected 1");
        end
    endtask

    task automatic txn(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       output logic hit, output logic [31:0] rd);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        wait_ready();
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("lookup_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clock); #1;
        check("resp_valid_t2", {31'd0, resp_valid}, 32'd1);
        hit = resp_hit;
        rd  = resp_data;
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
        @(posedge clock); #2;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    // Count cycles with flush_busy high, starting from the current sample point.
    task automatic count_busy(output int n);
        n = 0;
        while (flush_busy && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    initial begin
        logic        h;
        logic [31:0] rd;
        int          nb;

        // Group A: basic write/read, read-no-allocate.
        vecs[0]  = '{1'b1, 1'b1, 8'h13, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 8'h13, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b0, 8'h22, 32'h0,        1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 8'h22, 32'h0,        1'b0, 32'h0};
        // Group B: three writes into set 3, third evicts way 0.
        vecs[4]  = '{1'b1, 1'b1, 8'h03, 32'h1,        1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 8'h07, 32'h2,        1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 8'h0B, 32'h3,        1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 8'h03, 32'h0,        1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 8'h07, 32'h0,        1'b1, 32'h2};
        vecs[9]  = '{1'b0, 1'b0, 8'h0B, 32'h0,        1'b1, 32'h3};
        // Group C: write hit leaves rr alone, then round-robin across both ways.
        vecs[10] = '{1'b1, 1'b1, 8'h13, 32'h5,        1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 8'h13, 32'h9,        1'b1, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 8'h13, 32'h0,        1'b1, 32'h9};
        vecs[13] = '{1'b0, 1'b1, 8'h03, 32'h7,        1'b0, 32'h0};
        vecs[14] = '{1'b0, 1'b1, 8'h07, 32'h8,        1'b0, 32'h0};
        vecs[15] = '{1'b0, 1'b0, 8'h13, 32'h0,        1'b0, 32'h0};
        vecs[16] = '{1'b0, 1'b0, 8'h03, 32'h0,        1'b1, 32'h7};
        vecs[17] = '{1'b0, 1'b0, 8'h07, 32'h0,        1'b1, 32'h8};
        vecs[18] = '{1'b0, 1'b1, 8'h0B, 32'hA,        1'b0, 32'h0};
        vecs[19] = '{1'b0, 1'b0, 8'h03, 32'h0,        1'b0, 32'h0};
        vecs[20] = '{1'b0, 1'b0, 8'h07, 32'h0,        1'b1, 32'h8};

        #2;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) do_reset();
            txn(vecs[i].wr, vecs[i].addr, vecs[i].data, h, rd);
            check($sformatf("vec%0d_hit", i), {31'd0, h}, {31'd0, vecs[i].hit});
            check($sformatf("vec%0d_data", i), rd, vecs[i].rdata);
        end

        // Back-pressure on a read hit, flush raised while the response is held.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 8'h07;
        wait_ready();
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin
                flush = 1'b0;
                check("bp_flush_busy", {31'd0, flush_busy}, 32'd1);
            end
            check($sformatf("bp%0d_valid", k), {31'd0, resp_valid}, 32'd1);
            check($sformatf("bp%0d_hit", k), {31'd0, resp_hit}, 32'd1);
            check($sformatf("bp%0d_data", k), resp_data, 32'h8);
            check($sformatf("bp%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
            if (k == 2) flush = 1'b1;
            @(posedge clock); #1;
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_resp_done", {31'd0, resp_valid}, 32'd0);
        // One IDLE cycle with the flush pending, then four FLUSH cycles.
        count_busy(nb);
        check("pending_flush_cycles", nb, 32'd5);
        check("after_flush_ready", {31'd0, req_ready}, 32'd1);
        txn(1'b0, 8'h07, 32'h0, h, rd);
        check("after_flush_hit", {31'd0, h}, 32'd0);
        check("after_flush_data", rd, 32'd0);

        // Flush beats a simultaneous request in IDLE.
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 8'h07;
        #1;
        check("flush_vs_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clock); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        count_busy(nb);
        check("idle_flush_cycles", nb, 32'd4);
        check("idle_flush_ready", {31'd0, req_ready}, 32'd1);

`ifdef SET_ASSOC_CACHE_STATS_EN
        check("stat_hits_clr0", {16'd0, stat_hits}, 32'd0);
        txn(1'b1, 8'h01, 32'h1, h, rd);
        txn(1'b0, 8'h01, 32'h0, h, rd);
        txn(1'b0, 8'h01, 32'h0, h, rd);
        txn(1'b1, 8'h01, 32'h2, h, rd);
        txn(1'b0, 8'h02, 32'h0, h, rd);
        check("stat_hits", {16'd0, stat_hits}, 32'd3);
        check("stat_misses", {16'd0, stat_misses}, 32'd2);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        count_busy(nb);
        check("stat_hits_flushed", {16'd0, stat_hits}, 32'd0);
        check("stat_misses_flushed", {16'd0, stat_misses}, 32'd0);
`endif

        // Reset while a write is in LOOKUP: no response and nothing retained.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h05;
        req_data  = 32'h55;
        wait_ready();
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("midrst_valid0", {31'd0, resp_valid}, 32'd0);
        check("midrst_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clock); #1;
        check("midrst_valid1", {31'd0, resp_valid}, 32'd0);
        @(posedge clock); #2;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("midrst_valid2", {31'd0, resp_valid}, 32'd0);
        check("midrst_ready_after", {31'd0, req_ready}, 32'd1);
        txn(1'b0, 8'h05, 32'h0, h, rd);
        check("midrst_read_hit", {31'd0, h}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
